// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtc_bus_sequencer_if : requester handshake plus RTC chip bus pins
// Rev 1.0
// ---------------------------------------------------------------------------
interface rtc_bus_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   req_we;
  logic [8*NUM_CH-1:0] req_addr;
  logic [8*NUM_CH-1:0] req_wdata;
  logic [NUM_CH-1:0]   ack;
  logic [NUM_CH-1:0]   wrerr;
  logic [7:0]          rdata;
  logic                busy;
  logic [CW-1:0]       gnt_id;
  logic [7:0]          ADin;
  logic [7:0]          ADout;
  logic                oe;
  logic                ad;
  logic                cs;
  logic                rd;
  logic                wr;

  modport master (
    input  req, req_we, req_addr, req_wdata, ADin,
    output ack, wrerr, rdata, busy, gnt_id, ADout, oe, ad, cs, rd, wr
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, ADin,
    input  ack, wrerr, rdata, busy, gnt_id, ADout, oe, ad, cs, rd, wr
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtc_bus_sequencer : round-robin multi-channel master for the muxed RTC bus
// Optional write readback/verify enabled by macro RTC_SEQ_RDBACK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module rtc_bus_sequencer #(
  parameter int NUM_CH = 4,
  parameter int T_ADDR = 4,
  parameter int T_GAP  = 2,
  parameter int T_DATA = 6,
  parameter int T_REC  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rtc_bus_sequencer_if.master  bus
);

  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW = 16;
`ifdef RTC_SEQ_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_GAP  = 3'd2,
    S_DATA = 3'd3,
    S_REC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              rb_q, rb_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] wrerr_q, wrerr_d;
  logic              ad_q, ad_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              oe_q, oe_d;
  logic [7:0]        adout_q, adout_d;

  logic              found;
  int                sel;
  int                idx;
  logic              wop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      rb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      wrerr_q <= '0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      adout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      rb_q    <= rb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      wrerr_q <= wrerr_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      adout_q <= adout_d;
    end
  end

  // Round-robin search: first requester at or after the pointer
  always_comb begin
    found = 1'b0;
    sel   = 0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    rb_d    = rb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ADDR;
          cnt_d   = CNTW'(T_ADDR - 1);
          gnt_d   = CW'(sel);
          ptr_d   = CW'((sel + 1) % NUM_CH);
          we_d    = bus.req_we[sel];
          addr_d  = bus.req_addr[8*sel +: 8];
          wdata_d = bus.req_wdata[8*sel +: 8];
          rb_d    = 1'b0;
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNTW'(T_GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNTW'(T_DATA - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          if (!we_q || rb_q) begin
            rdata_d = bus.ADin;
          end
          state_d = S_REC;
          cnt_d   = CNTW'(T_REC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REC: begin
        if (cnt_q == '0) begin
          // A verified write loops back for a second, read-only pass
          if (RDBACK && we_q && !rb_q) begin
            state_d = S_ADDR;
            cnt_d   = CNTW'(T_ADDR - 1);
            rb_d    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin values derived from the next state so they register glitch-free
  always_comb begin
    wop_d   = we_d && !rb_d;
    ad_d    = !(state_d == S_ADDR);
    cs_d    = !((state_d == S_ADDR) || (state_d == S_GAP) || (state_d == S_DATA));
    wr_d    = !((state_d == S_DATA) && wop_d);
    rd_d    = !((state_d == S_DATA) && !wop_d);
    oe_d    = (state_d == S_ADDR) || ((state_d == S_DATA) && wop_d);
    adout_d = '0;
    if (state_d == S_ADDR) begin
      adout_d = addr_d;
    end else if ((state_d == S_DATA) && wop_d) begin
      adout_d = wdata_d;
    end
    ack_d   = '0;
    wrerr_d = '0;
    if (state_d == S_DONE) begin
      ack_d[gnt_d]   = 1'b1;
      wrerr_d[gnt_d] = RDBACK && we_d && (rdata_d != wdata_d);
    end
  end

  assign bus.ack    = ack_q;
  assign bus.wrerr  = wrerr_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.gnt_id = gnt_q;
  assign bus.ADout  = adout_q;
  assign bus.oe     = oe_q;
  assign bus.ad     = ad_q;
  assign bus.cs     = cs_q;
  assign bus.rd     = rd_q;
  assign bus.wr     = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rtc_bus_sequencer : randomized bench with RTC chip model and RR reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rtc_bus_sequencer;

  localparam int NUM_CH = 4;
  localparam int T_A    = 4;
  localparam int T_G    = 2;
  localparam int T_D    = 6;
  localparam int T_R    = 4;
  localparam int PASS_CYC = T_A + T_G + T_D + T_R;
`ifdef RTC_SEQ_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  logic clk;
  logic rst_n;

  rtc_bus_sequencer_if #(.NUM_CH(NUM_CH)) bif ();

  rtc_bus_sequencer #(
    .NUM_CH (NUM_CH),
    .T_ADDR (T_A),
    .T_GAP  (T_G),
    .T_DATA (T_D),
    .T_REC  (T_R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // RTC chip model
  logic [7:0] chip_mem [256];
  logic [7:0] chip_addr;
  logic [7:0] corrupt;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) chip_mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (!bif.cs && !bif.ad) chip_addr <= bif.ADout;
      if (!bif.cs && !bif.wr) chip_mem[chip_addr] <= bif.ADout;
    end
  end

  assign bif.ADin = (!bif.rd) ? (chip_mem[chip_addr] ^ corrupt) : 8'h00;

  // Bus monitor
  int   m_ad, m_cs, m_rd, m_wr, m_oe, m_perr;
  logic [7:0] mon_addr, mon_wd;
  initial begin
    m_ad = 0; m_cs = 0; m_rd = 0; m_wr = 0; m_oe = 0; m_perr = 0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bif.ad) begin
        m_ad++;
        if (bif.ADout !== mon_addr || bif.oe !== 1'b1) m_perr++;
      end
      if (!bif.cs) m_cs++;
      if (!bif.wr) begin
        m_wr++;
        if (bif.ADout !== mon_wd || bif.oe !== 1'b1) m_perr++;
      end
      if (!bif.rd) begin
        m_rd++;
        if (bif.oe !== 1'b0) m_perr++;
      end
      if (bif.oe) m_oe++;
      if (!bif.ad && (!bif.rd || !bif.wr)) m_perr++;
      if ((!bif.ad || !bif.rd || !bif.wr) && bif.cs) m_perr++;
    end
  end

  // Reference model state
  logic [7:0] ref_mem [256];
  int         ref_ptr;
  logic [7:0] ref_rdata;
  logic       ch_we   [NUM_CH];
  logic [7:0] ch_addr [NUM_CH];
  logic [7:0] ch_wd   [NUM_CH];
  bit         pulse_en;
  logic [3:0] pulse_bit;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_ptr   = 0;
    ref_rdata = 8'h00;
  endtask

  function automatic int rr_pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      if (pend[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    end
    return 0;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < NUM_CH; i++) begin
      bif.req_we[i]          = ch_we[i];
      bif.req_addr[8*i +: 8] = ch_addr[i];
      bif.req_wdata[8*i +: 8] = ch_wd[i];
    end
  endtask

  // Requests in mask are held until each is acked; called at a negedge
  task automatic serve_mask(input logic [3:0] mask);
    logic [3:0] pending;
    bit   first, got;
    int   e, p, exp_ch, exp_lat;
    int   b_ad, b_cs, b_rd, b_wr, b_oe, b_perr;
    logic [7:0] exp_rd;
    pending = mask;
    first   = 1'b1;
    drive_fields();
    bif.req = pending;
    while (pending != 4'b0000) begin
      exp_ch   = rr_pick(pending, ref_ptr);
      p        = (ch_we[exp_ch] && RDBACK) ? 2 : 1;
      exp_lat  = (first ? 1 : 2) + PASS_CYC * p;
      mon_addr = ch_addr[exp_ch];
      mon_wd   = ch_wd[exp_ch];
      b_ad = m_ad; b_cs = m_cs; b_rd = m_rd; b_wr = m_wr; b_oe = m_oe; b_perr = m_perr;
      e = 0; got = 1'b0;
      while (!got && e < 100) begin
        @(posedge clk); e++;
        @(negedge clk);
        if (bif.ack != '0) got = 1'b1;
        else begin
          if (e == 3) begin
            bif.req_we[exp_ch]          = ~ch_we[exp_ch];
            bif.req_addr[8*exp_ch +: 8] = ~ch_addr[exp_ch];
            bif.req_wdata[8*exp_ch +: 8] = ~ch_wd[exp_ch];
          end
          if (pulse_en && e == 5) bif.req = pending | pulse_bit;
          if (pulse_en && e == 6) bif.req = pending;
        end
      end
      if (!got) begin
        check_val("ack_timeout", 32'd0, 32'd1);
        bif.req = '0;
        return;
      end
      drive_fields();
      if (ch_we[exp_ch]) exp_rd = RDBACK ? (ch_wd[exp_ch] ^ corrupt) : ref_rdata;
      else               exp_rd = ref_mem[ch_addr[exp_ch]] ^ corrupt;
      check_val("latency", e, exp_lat);
      check_val("ack", bif.ack, 32'(1 << exp_ch));
      check_val("gnt_id", bif.gnt_id, exp_ch);
      check_val("rdata", bif.rdata, exp_rd);
      check_val("wrerr", bif.wrerr,
                (RDBACK && ch_we[exp_ch] && corrupt != 0) ? 32'(1 << exp_ch) : 32'd0);
      check_val("ad_low", m_ad - b_ad, T_A * p);
      check_val("cs_low", m_cs - b_cs, (T_A + T_G + T_D) * p);
      check_val("wr_low", m_wr - b_wr, ch_we[exp_ch] ? T_D : 0);
      check_val("rd_low", m_rd - b_rd, (!ch_we[exp_ch] || RDBACK) ? T_D : 0);
      check_val("oe_cyc", m_oe - b_oe, T_A * p + (ch_we[exp_ch] ? T_D : 0));
      check_val("bus_proto", m_perr - b_perr, 0);
      if (ch_we[exp_ch]) ref_mem[ch_addr[exp_ch]] = ch_wd[exp_ch];
      ref_rdata = exp_rd;
      ref_ptr   = (exp_ch + 1) % NUM_CH;
      pending[exp_ch] = 1'b0;
      bif.req = pending;
      first   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_val("ack_after", bif.ack, 0);
    check_val("busy_after", bif.busy, 0);
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [7:0] a, input logic [7:0] d);
    ch_we[ch] = we; ch_addr[ch] = a; ch_wd[ch] = d;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bif.req = '0; bif.req_we = '0; bif.req_addr = '0; bif.req_wdata = '0;
    corrupt = 8'h00; pulse_en = 1'b0; pulse_bit = 4'b0000;
    mon_addr = 8'h00; mon_wd = 8'h00;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b0, 8'h00, 8'h00);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ad", bif.ad, 1);
    check_val("rst_cs", bif.cs, 1);
    check_val("rst_rd", bif.rd, 1);
    check_val("rst_wr", bif.wr, 1);
    check_val("rst_oe", bif.oe, 0);
    check_val("rst_adout", bif.ADout, 0);
    check_val("rst_ack", bif.ack, 0);
    check_val("rst_wrerr", bif.wrerr, 0);
    check_val("rst_rdata", bif.rdata, 0);
    check_val("rst_busy", bif.busy, 0);
    check_val("rst_gnt", bif.gnt_id, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, then a read of a freshly written location
    set_ch(0, 1'b1, 8'h21, 8'h45);
    serve_mask(4'b0001);
    set_ch(1, 1'b1, 8'h23, 8'h59);
    serve_mask(4'b0010);
    set_ch(2, 1'b0, 8'h23, 8'h00);
    serve_mask(4'b0100);

    // Reset while a write is in its data phase
    set_ch(1, 1'b1, 8'h30, 8'h77);
    mon_addr = 8'h30; mon_wd = 8'h77;
    drive_fields();
    bif.req = 4'b0010;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_wr", bif.wr, 0);
    rst_n = 1'b0;
    #1;
    check_val("arst_wr", bif.wr, 1);
    check_val("arst_cs", bif.cs, 1);
    check_val("arst_oe", bif.oe, 0);
    check_val("arst_busy", bif.busy, 0);
    check_val("arst_ack", bif.ack, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_val("arst_gnt", bif.gnt_id, 0);
    rst_n = 1'b1;
    serve_mask(4'b0010);

    // All four channels at once from a fresh pointer
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    serve_mask(4'b1111);

    // One-cycle pulse on another channel while busy
    pulse_en = 1'b1; pulse_bit = 4'b1000;
    set_ch(0, 1'b0, 8'h21, 8'h00);
    serve_mask(4'b0001);
    pulse_en = 1'b0;

    for (int it = 0; it < 24; it++) begin
      logic [3:0] m;
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) m = 4'(1 << $urandom_range(0, 3));
      else                           m = 4'($urandom_range(1, 15));
      serve_mask(m);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    if (RDBACK) begin
      corrupt = 8'h01;
      set_ch(0, 1'b1, 8'h21, 8'h45);
      serve_mask(4'b0001);
      corrupt = 8'h00;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
